// File: rtl/ir_prefix_latch_pkg.sv
// Shared opcode constants, prefix-vector bit positions and decode-table type
// for the instruction register / prefix tracker.
package z80_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_DD  = 8'hDD;
  localparam logic [7:0] OP_FD  = 8'hFD;
  localparam logic [7:0] OP_CB  = 8'hCB;
  localparam logic [7:0] OP_ED  = 8'hED;

  localparam int PFX_IXY0 = 4;
  localparam int PFX_IXY1 = 3;
  localparam int PFX_XX   = 2;
  localparam int PFX_CB   = 1;
  localparam int PFX_ED   = 0;

  typedef enum logic [1:0] {
    TBL_XX = 2'd0,
    TBL_CB = 2'd1,
    TBL_ED = 2'd2
  } tbl_e;

  function automatic logic [4:0] pfx_encode(input tbl_e tbl, input logic ixy);
    logic [4:0] p;
    p           = '0;
    p[PFX_IXY0] = ~ixy;
    p[PFX_IXY1] = ixy;
    p[PFX_XX]   = (tbl == TBL_XX);
    p[PFX_CB]   = (tbl == TBL_CB);
    p[PFX_ED]   = (tbl == TBL_ED);
    return p;
  endfunction

  function automatic logic is_prefix_op(input logic [7:0] op);
    return (op == OP_DD) || (op == OP_FD) || (op == OP_CB) || (op == OP_ED);
  endfunction

endpackage

// File: rtl/ir_prefix_latch_if.sv
// Bus between the M1/sequencer control and the IR/prefix tracker that feeds
// pla_decode.
interface ir_prefix_latch_if;
  logic [7:0] db;
  logic       ir_we;
  logic       ir_we_xcb;
  logic       in_halt;
  logic       int_ack;
  logic [7:0] ir;
  logic [4:0] prefix;
  logic       iy_sel;
  logic       pfx_pending;

  modport master (
    output db, ir_we, ir_we_xcb, in_halt, int_ack,
    input  ir, prefix, iy_sel, pfx_pending
  );

  modport slave (
    input  db, ir_we, ir_we_xcb, in_halt, int_ack,
    output ir, prefix, iy_sel, pfx_pending
  );
endinterface

// File: rtl/ir_prefix_latch_pfx_next.sv
// Next decode-table / index-register state, derived from the byte currently
// held in the IR and the table it was decoded under.
module pfx_next
  import z80_pkg::*;
(
  input  logic [7:0] ir_old,
  input  tbl_e       tbl_old,
  input  logic       ixy_old,
  input  logic       iy_old,
  input  logic       xcb,
  output tbl_e       tbl_nx,
  output logic       ixy_nx,
  output logic       iy_nx,
  output logic       xcb_ok
);

  always_comb begin
    tbl_nx = TBL_XX;
    ixy_nx = 1'b0;
    iy_nx  = iy_old;
    // The 4th byte of DD/FD CB d op is only meaningful right after the CB.
    xcb_ok = xcb && (tbl_old == TBL_XX) && ixy_old && (ir_old == OP_CB);
    if (tbl_old == TBL_XX) begin
      case (ir_old)
        OP_DD: begin
          ixy_nx = 1'b1;
          iy_nx  = 1'b0;
        end
        OP_FD: begin
          ixy_nx = 1'b1;
          iy_nx  = 1'b1;
        end
        OP_CB: begin
          tbl_nx = TBL_CB;
          ixy_nx = ixy_old;
        end
        OP_ED: tbl_nx = TBL_ED;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ir_prefix_latch.sv
// Instruction register and DD/FD/CB/ED prefix tracker; presents the byte
// under decode and one-hot table/index qualifiers to pla_decode.
module ir_prefix_latch
  import z80_pkg::*;
#(
  parameter logic [7:0] NOP_OP    = 8'h00,
  parameter logic [4:0] PFX_RESET = 5'b10100
) (
  input logic              clk,
  input logic              nreset,
  ir_prefix_latch_if.slave bus
);

  logic [7:0] ir_q, ir_d;
  tbl_e       tbl_q, tbl_d, tbl_nx;
  logic       ixy_q, ixy_d, ixy_nx;
  logic       iy_q, iy_d, iy_nx;
  logic [4:0] pfx_q, pfx_d;
  logic       pend_q, pend_d;
  logic       xcb_ok;

  // A simultaneous ir_we wins, so the extra-byte strobe is masked here.
  pfx_next u_pfx_next (
    .ir_old  (ir_q),
    .tbl_old (tbl_q),
    .ixy_old (ixy_q),
    .iy_old  (iy_q),
    .xcb     (bus.ir_we_xcb && !bus.ir_we),
    .tbl_nx  (tbl_nx),
    .ixy_nx  (ixy_nx),
    .iy_nx   (iy_nx),
    .xcb_ok  (xcb_ok)
  );

  always_comb begin
    ir_d  = ir_q;
    tbl_d = tbl_q;
    ixy_d = ixy_q;
    iy_d  = iy_q;
    if (bus.int_ack) begin
      ir_d  = NOP_OP;
      tbl_d = TBL_XX;
      ixy_d = 1'b0;
      iy_d  = 1'b0;
    end else if (bus.ir_we || xcb_ok) begin
      ir_d  = bus.in_halt ? NOP_OP : bus.db;
      tbl_d = tbl_nx;
      ixy_d = ixy_nx;
      iy_d  = iy_nx;
    end
    pfx_d  = pfx_encode(tbl_d, ixy_d);
    pend_d = (tbl_d == TBL_XX) && is_prefix_op(ir_d);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ir_q   <= NOP_OP;
      tbl_q  <= TBL_XX;
      ixy_q  <= 1'b0;
      iy_q   <= 1'b0;
      pfx_q  <= PFX_RESET;
      pend_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      tbl_q  <= tbl_d;
      ixy_q  <= ixy_d;
      iy_q   <= iy_d;
      pfx_q  <= pfx_d;
      pend_q <= pend_d;
    end
  end

  assign bus.ir          = ir_q;
  assign bus.prefix      = pfx_q;
  assign bus.iy_sel      = iy_q;
  assign bus.pfx_pending = pend_q;

  a_no_dual_strobe : assert property (@(posedge clk) disable iff (!nreset)
    !(bus.ir_we && bus.ir_we_xcb));

  a_prefix_onehot : assert property (@(posedge clk) disable iff (!nreset)
    $onehot(pfx_q[4:3]) && $onehot(pfx_q[2:0]));

endmodule

// File: tb/tb_ir_prefix_latch.sv
// Directed bench for ir_prefix_latch: each step queues its expected IR/prefix
// state and compares it one clock later.
module tb_ir_prefix_latch;

  typedef struct {
    logic [7:0] ir;
    logic [4:0] pfx;
    logic       iy;
    logic       pend;
  } exp_t;

  logic clk;
  logic nreset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_step  = 0;
  exp_t sb_q[$];

  ir_prefix_latch_if bus ();

  ir_prefix_latch dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".ir"}, bus.ir, e.ir);
    chk({tag, ".prefix"}, {3'b000, bus.prefix}, {3'b000, e.pfx});
    chk({tag, ".iy_sel"}, {7'd0, bus.iy_sel}, {7'd0, e.iy});
    chk({tag, ".pfx_pending"}, {7'd0, bus.pfx_pending}, {7'd0, e.pend});
  endtask

  task automatic step(input logic [7:0] d, input logic we, input logic xcb,
                      input logic halt, input logic ack,
                      input logic [7:0] e_ir, input logic [4:0] e_pfx,
                      input logic e_iy, input logic e_pend);
    exp_t e;
    @(negedge clk);
    bus.db        = d;
    bus.ir_we     = we;
    bus.ir_we_xcb = xcb;
    bus.in_halt   = halt;
    bus.int_ack   = ack;
    sb_q.push_back('{ir: e_ir, pfx: e_pfx, iy: e_iy, pend: e_pend});
    @(posedge clk);
    #1;
    bus.ir_we     = 1'b0;
    bus.ir_we_xcb = 1'b0;
    bus.int_ack   = 1'b0;
    bus.in_halt   = 1'b0;
    n_step++;
    if (sb_q.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk_all($sformatf("step%0d", n_step), e);
    end
  endtask

  initial begin
    nreset        = 1'b0;
    bus.db        = 8'h00;
    bus.ir_we     = 1'b0;
    bus.ir_we_xcb = 1'b0;
    bus.in_halt   = 1'b0;
    bus.int_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '{ir: 8'h00, pfx: 5'b10100, iy: 1'b0, pend: 1'b0});
    @(negedge clk);
    nreset = 1'b1;

    //   db     we    xcb   halt  ack   ir     prefix    iy    pend
    step(8'h3E, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3E, 5'b10100, 1'b0, 1'b0);
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b10100, 1'b0, 1'b1);
    step(8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21, 5'b01100, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b10100, 1'b0, 1'b0);
    // FD CB d op: displacement cycle carries no strobe
    step(8'hFD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, 5'b10100, 1'b0, 1'b1);
    step(8'hCB, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCB, 5'b01100, 1'b1, 1'b1);
    step(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCB, 5'b01100, 1'b1, 1'b1);
    step(8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 5'b01010, 1'b1, 1'b0);
    // DD ED 44: ED drops the index qualifier
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b10100, 1'b1, 1'b1);
    step(8'hED, 1'b1, 1'b0, 1'b0, 1'b0, 8'hED, 5'b01100, 1'b0, 1'b1);
    step(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 5'b10001, 1'b0, 1'b0);
    // DD FD 7E: last prefix wins
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b10100, 1'b0, 1'b1);
    step(8'hFD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, 5'b01100, 1'b0, 1'b1);
    step(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 5'b01100, 1'b1, 1'b0);
    // halt loop
    step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'b10100, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'b10100, 1'b1, 1'b0);
    // stray xcb strobe outside DD/FD CB is ignored
    step(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'b10100, 1'b1, 1'b0);
    // int_ack beats a same-cycle load
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b10100, 1'b1, 1'b1);
    step(8'hFD, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'b10100, 1'b0, 1'b0);
    // DD CB d op keeps IX selection into the CB table
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b10100, 1'b0, 1'b1);
    step(8'hCB, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCB, 5'b01100, 1'b0, 1'b1);
    step(8'h46, 1'b0, 1'b1, 1'b0, 1'b0, 8'h46, 5'b01010, 1'b0, 1'b0);
    // mid-chain reset: DD FD leaves IY selected, then reset between edges
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b10100, 1'b0, 1'b1);
    step(8'hFD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, 5'b01100, 1'b0, 1'b1);
    step(8'hDD, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 5'b01100, 1'b1, 1'b1);
    #2;
    nreset = 1'b0;
    #1;
    chk_all("async_reset", '{ir: 8'h00, pfx: 5'b10100, iy: 1'b0, pend: 1'b0});
    @(negedge clk);
    nreset = 1'b1;
    step(8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21, 5'b10100, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
